// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Tuse/Tnew encodings are in cycles relative to the D and E stages.
package hazard_scoreboard_pkg;

    localparam int REG_MAX_W  = 8;
    localparam int TNEW_MAX_W = 4;

    localparam logic [1:0] TUSE_D = 2'd0;
    localparam logic [1:0] TUSE_E = 2'd1;
    localparam logic [1:0] TUSE_M = 2'd2;

    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    localparam logic [1:0] TNEW_MF   = 2'd1;

    // Fields are sized to the widest supported configuration; narrower
    // module parameters zero-extend into them.
    typedef struct packed {
        logic                  valid;
        logic [REG_MAX_W-1:0]  dst;
        logic [TNEW_MAX_W-1:0] tnew;
    } sb_entry_t;

    function automatic logic [TNEW_MAX_W-1:0] tnew_dec(input logic [TNEW_MAX_W-1:0] t);
        return (t == '0) ? t : t - TNEW_MAX_W'(1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Multiply/divide busy counter: loads the unit latency on a start and
// counts down to zero; busy while non-zero.
module md_busy_counter #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard for a classic 5-stage pipeline with an
// optional multi-cycle multiply/divide interlock (macro HAZARD_MD_UNIT_EN).
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int DEPTH    = 3,
    parameter int TNEW_W   = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_rs_use,
    input  logic              id_rt_use,
    input  logic [TNEW_W-1:0] id_rs_tuse,
    input  logic [TNEW_W-1:0] id_rt_tuse,
    input  logic [REG_W-1:0]  id_dst,
    input  logic [TNEW_W-1:0] id_tnew,
    input  logic              id_md_op,
    input  logic              id_md_start,
    input  logic              id_md_div,
    input  logic              flush,
    output logic              stall,
    output logic              md_busy,
    output logic [DEPTH-1:0]  sb_valid
);

    sb_entry_t ent [DEPTH];
    logic      issue;
    logic      rs_hit_stall;
    logic      rt_hit_stall;
    logic      md_stall;

    // Walk oldest to youngest so the youngest matching writer has the last word.
    always_comb begin
        rs_hit_stall = 1'b0;
        rt_hit_stall = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent[i].valid && ent[i].dst != '0 && ent[i].dst == REG_MAX_W'(id_rs))
                rs_hit_stall = ent[i].tnew > TNEW_MAX_W'(id_rs_tuse);
            if (ent[i].valid && ent[i].dst != '0 && ent[i].dst == REG_MAX_W'(id_rt))
                rt_hit_stall = ent[i].tnew > TNEW_MAX_W'(id_rt_tuse);
        end
    end

    assign stall = id_valid && ((id_rs_use && rs_hit_stall) ||
                                (id_rt_use && rt_hit_stall) || md_stall);
    assign issue = id_valid && !stall;

    always_comb begin
        sb_valid = '0;
        for (int i = 0; i < DEPTH; i++) sb_valid[i] = ent[i].valid;
    end

    // D -> E load, then E -> M -> W shift with saturating Tnew countdown.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                ent[i].valid <= ent[i-1].valid;
                ent[i].dst   <= ent[i-1].dst;
                ent[i].tnew  <= tnew_dec(ent[i-1].tnew);
            end
            if (issue) begin
                ent[0].valid <= 1'b1;
                ent[0].dst   <= REG_MAX_W'(id_dst);
                ent[0].tnew  <= TNEW_MAX_W'(id_tnew);
            end else begin
                ent[0] <= '0;
            end
        end
    end

`ifdef HAZARD_MD_UNIT_EN
    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (issue && id_md_start),
        .is_div (id_md_div),
        .busy   (md_busy)
    );
    assign md_stall = id_md_op && md_busy;
`else
    logic unused_md_inputs;
    assign unused_md_inputs = ^{id_md_op, id_md_start, id_md_div};
    assign md_busy  = 1'b0;
    assign md_stall = 1'b0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_W, default 5, register address width.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked stages after decode (E, M, W).
REQ-003 SHALL have parameter TNEW_W, default 2, width of Tnew/Tuse fields.
REQ-004 SHALL have parameter MULT_LAT, default 5, mult/multu busy cycles.
REQ-005 SHALL have parameter DIV_LAT, default 10, div/divu busy cycles.
REQ-006 SHALL have ports:
- clk  in  1  clock, single domain.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  decode holds a real instruction.
- id_rs, id_rt  in  REG_W  source addresses.
- id_rs_use, id_rt_use  in  1  source actually read.
- id_rs_tuse, id_rt_tuse  in  TNEW_W  cycles until value needed (0=D, 1=E, 2=M).
- id_dst  in  REG_W  destination; 0 means no write.
- id_tnew  in  TNEW_W  cycles after entering E until result forwardable.
- id_md_op  in  1  any mult/div/mfhi/mflo/mthi/mtlo.
- id_md_start  in  1  mult/multu/div/divu.
- id_md_div  in  1  start is a divide.
- flush  in  1  clear tracked instructions.
- stall  out  1  freeze F/D, bubble into E.
- md_busy  out  1  multiply/divide unit busy.
- sb_valid  out  DEPTH  entry valid bits, bit 0 = E.

Function
REQ-007 SHALL hold DEPTH entries {valid, dst, tnew}; entry 0 = E, entry DEPTH-1 = W.
REQ-008 Each cycle SHALL shift entries one stage older; tnew decrements, saturating at 0; oldest entry discarded.
REQ-009 Issue = id_valid && !stall; on issue entry 0 SHALL load {1, id_dst, id_tnew}; otherwise entry 0 loads valid=0 (bubble).
REQ-010 Entries with dst==0 SHALL never match.
REQ-011 For each used source, the youngest valid entry with matching dst SHALL decide; data stall when its tnew > tuse; older matches ignored.
REQ-012 stall SHALL be combinational: data stall on rs or rt, OR md stall (REQ-015); stall is 0 when id_valid=0.
REQ-013 Issue of id_md_start SHALL load counter with MULT_LAT or DIV_LAT (id_md_div) at that edge; counter decrements to 0 each cycle.
REQ-014 md_busy SHALL equal (counter != 0); busy lasts exactly LAT cycles after issue.
REQ-015 md stall = id_valid && id_md_op && md_busy.
REQ-016 flush SHALL invalidate all entries at the edge, overriding issue; MD counter is unaffected.
REQ-017 Counter width SHALL be wide enough for max(MULT_LAT, DIV_LAT).

Reset
REQ-018 On reset at a clock edge: all entries invalid, dst=0, tnew=0, counter=0; stall=0, md_busy=0, sb_valid=0 from the following cycle.
REQ-019 Reset mid-operation (MD busy, loads in flight) SHALL discard all state; reset has priority over flush and issue.

Configuration
REQ-020 Macro HAZARD_MD_UNIT_EN: defined -> MD counter and md stall per REQ-013..015; undefined -> no counter, md_busy tied 0, md stall term 0, MD inputs ignored.

Structure
REQ-021 Shared package SHALL hold entry record typedef, Tuse constants (TUSE_D=0, TUSE_E=1, TUSE_M=2), and default Tnew constants (ALU=1, LOAD=2, MF=1).
REQ-022 Single sub-module md_busy_counter SHALL implement REQ-013..014; instantiated only under HAZARD_MD_UNIT_EN.

Verification
REQ-023 lw dst=8 tnew=2 issued; next cycle addu rs=8 tuse=1 -> stall=1 one cycle, then 0 (forward from M).
REQ-024 addu dst=9 tnew=1 issued; next cycle beq rs=9 tuse=0 -> stall=1 one cycle; lw dst=9 instead -> stall 2 cycles.
REQ-025 lw dst=8 then ori dst=8 tnew=1, consumer rs=8 tuse=1 -> youngest (ori, tnew 0 in E... decremented) decides: stall=0.
REQ-026 div issued with DIV_LAT=10, mflo following -> md_busy=1 for 10 cycles, stall=1 for those cycles, mflo issues cycle 11; macro undefined -> no stall.
REQ-027 Stalled load-use with flush=1 -> sb_valid=0 next cycle, stall=0; reset during div -> md_busy=0 next cycle.
REQ-028 Consumer rs=0 after any writer, or dst=0 writer -> stall=0.
